// File: rtl/rd_ptr_empty_pkg.sv
// rd_ptr_empty_pkg
// Purpose: shared constants and Gray-code helpers for the asynchronous FIFO pointer
//          blocks (read-side rd_ptr_empty and the matching write-side block).
// Contents: ADDR_WIDTH / PTR_WIDTH defaults, bin2gray(), gray2bin().
// The helpers operate on 32-bit values; callers zero-extend their pointer and
// size-cast the result back, so any pointer width up to 32 bits is supported.
package rd_ptr_empty_pkg;

  localparam int unsigned ADDR_WIDTH = 6;
  localparam int unsigned PTR_WIDTH  = ADDR_WIDTH + 1;

  function automatic logic [31:0] bin2gray(input logic [31:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  // XOR prefix from the MSB down: each binary bit is the parity of all Gray
  // bits at or above it.
  function automatic logic [31:0] gray2bin(input logic [31:0] gray);
    logic [31:0] bin;
    bin[31] = gray[31];
    for (int i = 30; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage

// File: rtl/rd_ptr_empty_if.sv
// rd_ptr_empty_if
// Purpose: read-side FIFO pointer bundle between the read-domain client and rd_ptr_empty.
// Signals:
//   rd_en        client -> block  read request
//   wrt_ptr      client -> block  Gray write pointer from the write clock domain
//   rd_ptr       block  -> client registered Gray read pointer (to the write domain)
//   rd_addr      block  -> client memory read address
//   empty        block  -> client no unread word
//   almost_empty block  -> client fill level at or below threshold
//   rd_count     block  -> client unread word count
// Modports: master = read-domain client, slave = rd_ptr_empty.
interface rd_ptr_empty_if #(
  parameter int unsigned ADDR_WIDTH = rd_ptr_empty_pkg::ADDR_WIDTH
);
  localparam int unsigned PtrWidth = ADDR_WIDTH + 1;

  logic                  rd_en;
  logic [PtrWidth-1:0]   wrt_ptr;
  logic [PtrWidth-1:0]   rd_ptr;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic                  empty;
  logic                  almost_empty;
  logic [PtrWidth-1:0]   rd_count;

  modport master (
    output rd_en,
    output wrt_ptr,
    input  rd_ptr,
    input  rd_addr,
    input  empty,
    input  almost_empty,
    input  rd_count
  );

  modport slave (
    input  rd_en,
    input  wrt_ptr,
    output rd_ptr,
    output rd_addr,
    output empty,
    output almost_empty,
    output rd_count
  );

endinterface

// File: rtl/rd_ptr_empty_sync_w2r.sv
// sync_w2r
// Purpose: two-flop synchronizer carrying the Gray write pointer into the read domain.
// Ports:
//   i_clk  destination clock
//   i_rst  synchronous active-high reset, clears both stages
//   i_d    asynchronous input (must be registered at its source, no logic here)
//   o_q    synchronized output
module sync_w2r #(
  parameter int unsigned Width = 7
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [Width-1:0] i_d,
  output logic [Width-1:0] o_q
);

  logic [Width-1:0] r_meta;
  logic [Width-1:0] r_sync;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/rd_ptr_empty.sv
// rd_ptr_empty
// Purpose: read-side pointer and empty/almost-empty/count generation for an
//          asynchronous FIFO with Gray-coded pointers.
// Ports:
//   rd_clk  read-domain clock (rising edge only)
//   rd_rst  synchronous active-high reset
//   bus     rd_ptr_empty_if.slave: rd_en, wrt_ptr in; rd_ptr, rd_addr, empty,
//           almost_empty, rd_count out (all outputs registered)
// Parameters:
//   ADDR_WIDTH     memory address width; pointers carry one extra wrap bit
//   AEMPTY_THRESH  almost_empty asserts when rd_count <= this value
module rd_ptr_empty #(
  parameter int unsigned ADDR_WIDTH    = rd_ptr_empty_pkg::ADDR_WIDTH,
  parameter int unsigned AEMPTY_THRESH = 4
) (
  input  logic          rd_clk,
  input  logic          rd_rst,
  rd_ptr_empty_if.slave bus
);

  import rd_ptr_empty_pkg::*;

  localparam int unsigned PtrWidth = ADDR_WIDTH + 1;

  logic [PtrWidth-1:0] r_bin;
  logic [PtrWidth-1:0] r_ptr;
  logic [PtrWidth-1:0] r_count;
  logic                r_empty;
  logic                r_aempty;

  logic [PtrWidth-1:0] w_sync_ptr;
  logic [PtrWidth-1:0] w_sync_bin;
  logic [PtrWidth-1:0] w_bin_next;
  logic [PtrWidth-1:0] w_gray_next;
  logic [PtrWidth-1:0] w_count_next;
  logic                w_inc;

  sync_w2r #(
    .Width (PtrWidth)
  ) u_sync_w2r (
    .i_clk (rd_clk),
    .i_rst (rd_rst),
    .i_d   (bus.wrt_ptr),
    .o_q   (w_sync_ptr)
  );

  always_comb begin
    // Gating with the registered empty flag is the underflow guard.
    w_inc        = bus.rd_en & ~r_empty;
    w_bin_next   = r_bin + PtrWidth'(w_inc);
    w_gray_next  = PtrWidth'(bin2gray(32'(w_bin_next)));
    w_sync_bin   = PtrWidth'(gray2bin(32'(w_sync_ptr)));
    // Count uses the post-read pointer so a read and a synchronized write on
    // the same edge net out, and the last read raises empty immediately.
    w_count_next = w_sync_bin - w_bin_next;
  end

  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      r_bin    <= '0;
      r_ptr    <= '0;
      r_count  <= '0;
      r_empty  <= 1'b1;
      r_aempty <= 1'b1;
    end else begin
      r_bin    <= w_bin_next;
      r_ptr    <= w_gray_next;
      r_count  <= w_count_next;
      r_empty  <= (w_gray_next == w_sync_ptr);
      r_aempty <= (32'(w_count_next) <= AEMPTY_THRESH);
    end
  end

  assign bus.rd_ptr       = r_ptr;
  assign bus.rd_addr      = r_bin[ADDR_WIDTH-1:0];
  assign bus.empty        = r_empty;
  assign bus.almost_empty = r_aempty;
  assign bus.rd_count     = r_count;

endmodule

// File: tb/tb_rd_ptr_empty.sv
// tb_rd_ptr_empty
// Directed scenarios followed by randomized traffic, every edge checked against a
// word-count model: words written, words read, and a two-edge visibility delay on
// the write count.
module tb_rd_ptr_empty;

  logic clk = 1'b0;
  logic rst = 1'b1;

  rd_ptr_empty_if #(.ADDR_WIDTH(6)) bus ();

  rd_ptr_empty #(
    .ADDR_WIDTH    (6),
    .AEMPTY_THRESH (4)
  ) dut (
    .rd_clk (clk),
    .rd_rst (rst),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: total words written (m_wr), total words read (m_rd), write totals as
  // visible 1 and 2 edges later (m_p1, m_p2), and the unread count (m_cnt).
  int m_wr  = 0;
  int m_rd  = 0;
  int m_p1  = 0;
  int m_p2  = 0;
  int m_cnt = 0;

  function automatic logic [6:0] to_gray(input int v);
    logic [6:0] b;
    b = 7'(v);
    return b ^ (b >> 1);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    chk("empty",        32'(bus.empty),        32'(m_cnt == 0));
    chk("almost_empty", 32'(bus.almost_empty), 32'(m_cnt <= 4));
    chk("rd_ptr",       32'(bus.rd_ptr),       32'(to_gray(m_rd)));
    chk("rd_addr",      32'(bus.rd_addr),      32'(m_rd & 63));
    chk("rd_count",     32'(bus.rd_count),     32'(m_cnt));
  endtask

  // One rising edge: advance the model with the inputs in force, then compare
  // on the following falling edge.
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      m_rd  = 0;
      m_p1  = 0;
      m_p2  = 0;
      m_cnt = 0;
    end else begin
      if (bus.rd_en && m_cnt != 0) m_rd++;
      m_cnt = (m_p2 - m_rd) & 127;
      m_p2  = m_p1;
      m_p1  = m_wr;
    end
    @(negedge clk);
    check_model();
  endtask

  task automatic set_wr(input int v);
    m_wr        = v;
    bus.wrt_ptr = to_gray(v);
  endtask

  task automatic do_reset(input int cycles);
    rst       = 1'b1;
    bus.rd_en = 1'b0;
    set_wr(0);
    for (int i = 0; i < cycles; i++) tick();
    rst = 1'b0;
  endtask

  initial begin
    bus.rd_en   = 1'b0;
    bus.wrt_ptr = '0;
    @(negedge clk);

    // Reset values
    do_reset(2);
    chk("rst_empty",  32'(bus.empty),        32'd1);
    chk("rst_aempty", 32'(bus.almost_empty), 32'd1);
    chk("rst_ptr",    32'(bus.rd_ptr),       32'h00);
    chk("rst_addr",   32'(bus.rd_addr),      32'd0);
    chk("rst_count",  32'(bus.rd_count),     32'd0);

    // Single word: visible after the third edge, then one read empties it
    set_wr(1);
    tick();
    tick();
    chk("lat_edge2_empty", 32'(bus.empty), 32'd1);
    tick();
    chk("single_empty", 32'(bus.empty),    32'd0);
    chk("single_count", 32'(bus.rd_count), 32'd1);
    bus.rd_en = 1'b1;
    tick();
    bus.rd_en = 1'b0;
    chk("read1_addr",  32'(bus.rd_addr),  32'd1);
    chk("read1_ptr",   32'(bus.rd_ptr),   32'h01);
    chk("read1_empty", 32'(bus.empty),    32'd1);
    chk("read1_count", 32'(bus.rd_count), 32'd0);

    // Underflow guard
    do_reset(2);
    bus.rd_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("uflow_ptr",   32'(bus.rd_ptr),   32'h00);
      chk("uflow_count", 32'(bus.rd_count), 32'd0);
    end
    bus.rd_en = 1'b0;

    // Full FIFO and wrap of the address
    do_reset(2);
    set_wr(64);
    for (int i = 0; i < 3; i++) tick();
    chk("full_count",  32'(bus.rd_count),     32'd64);
    chk("full_aempty", 32'(bus.almost_empty), 32'd0);
    bus.rd_en = 1'b1;
    for (int i = 0; i < 64; i++) begin
      chk("wrap_addr_seq", 32'(bus.rd_addr), 32'(i));
      tick();
    end
    bus.rd_en = 1'b0;
    chk("wrap_addr",  32'(bus.rd_addr), 32'd0);
    chk("wrap_ptr",   32'(bus.rd_ptr),  32'h60);
    chk("wrap_empty", 32'(bus.empty),   32'd1);

    // Almost-empty threshold
    do_reset(2);
    set_wr(6);
    for (int i = 0; i < 3; i++) tick();
    chk("thr_count6",  32'(bus.rd_count),     32'd6);
    chk("thr_aempty0", 32'(bus.almost_empty), 32'd0);
    bus.rd_en = 1'b1;
    tick();
    tick();
    bus.rd_en = 1'b0;
    chk("thr_count4",  32'(bus.rd_count),     32'd4);
    chk("thr_aempty1", 32'(bus.almost_empty), 32'd1);

    // Reset in the middle of a read burst
    do_reset(2);
    set_wr(6);
    for (int i = 0; i < 3; i++) tick();
    chk("mid_count6", 32'(bus.rd_count), 32'd6);
    bus.rd_en = 1'b1;
    rst       = 1'b1;
    tick();
    chk("mid_empty",  32'(bus.empty),        32'd1);
    chk("mid_aempty", 32'(bus.almost_empty), 32'd1);
    chk("mid_ptr",    32'(bus.rd_ptr),       32'h00);
    chk("mid_addr",   32'(bus.rd_addr),      32'd0);
    chk("mid_count",  32'(bus.rd_count),     32'd0);
    rst       = 1'b0;
    bus.rd_en = 1'b0;
    set_wr(0);
    tick();

    // Randomized traffic; the writer never exceeds 64 unread words
    for (int i = 0; i < 3000; i++) begin
      bus.rd_en = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 399) == 0) begin
        rst = 1'b1;
        set_wr(0);
      end else begin
        rst = 1'b0;
        if ($urandom_range(0, 2) != 0 && (m_wr - m_rd) < 64) set_wr(m_wr + 1);
      end
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rd_ptr_empty.md
RD_PTR_EMPTY -- requirements
Module: rd_ptr_empty

Interface
REQ-001 Parameter: ADDR_WIDTH, default 6, memory address width; pointer width is ADDR_WIDTH+1.
REQ-002 Parameter: AEMPTY_THRESH, default 4, fill level at or below which almost_empty asserts.
REQ-003 Port: rd_clk  input  1  read-domain clock; all logic is clocked on the rising edge of rd_clk only.
REQ-004 Port: rd_rst  input  1  reset, synchronous and active-high.
REQ-005 Port: rd_en  input  1  read request; honoured only when empty=0.
REQ-006 Port: wrt_ptr  input  7  Gray-coded write pointer, launched from the write clock domain (asynchronous to rd_clk).
REQ-007 Port: rd_ptr  output  7  registered Gray-coded read pointer, sent to the write domain.
REQ-008 Port: rd_addr  output  6  memory read address, equal to rd_bin[5:0].
REQ-009 Port: empty  output  1  registered; 1 = no unread word.
REQ-010 Port: almost_empty  output  1  registered; 1 = rd_count <= AEMPTY_THRESH.
REQ-011 Port: rd_count  output  7  registered number of unread words (0..64) as seen from the read domain.

Function
REQ-012 wrt_ptr SHALL pass through a two-flop synchronizer clocked by rd_clk to give rq2_wrt_ptr, with no combinational logic before the first flop.
REQ-013 rd_bin_next SHALL equal rd_bin + (rd_en & ~empty), computed modulo 2^7.
REQ-014 rd_gray_next SHALL equal (rd_bin_next >> 1) ^ rd_bin_next.
REQ-015 On each rd_clk edge without reset: rd_bin <= rd_bin_next; rd_ptr <= rd_gray_next.
REQ-016 rd_en while empty=1 SHALL NOT change rd_bin, rd_ptr, rd_addr or rd_count.
REQ-017 empty SHALL be registered as (rd_gray_next == rq2_wrt_ptr).
REQ-018 rd_count SHALL be registered as (gray2bin(rq2_wrt_ptr) - rd_bin_next) mod 2^7.
REQ-019 almost_empty SHALL be registered as (that same next-count value <= AEMPTY_THRESH).
REQ-020 Latency: a wrt_ptr change stable before edge N SHALL be reflected in empty, rd_count and almost_empty after edge N+2.
REQ-021 Wrap-around: rd_addr SHALL wrap from 63 to 0, and the pointer MSB (rd_bin[6]) SHALL toggle on every wrap.
REQ-022 A read and a synchronized write arriving on the same edge SHALL net out: the count is computed from both updated values.
REQ-023 Reading the last unread word SHALL set empty=1 on the same edge that advances the pointer, so that no over-read is possible.

Reset
REQ-024 While rd_rst=1 at a rd_clk edge: rd_bin=0, rd_ptr=0, both synchronizer stages=0, rd_count=0, empty=1, almost_empty=1.
REQ-025 Reset asserted mid-operation SHALL override any rd_en in the same cycle. After release, operation resumes from pointer 0; the write side is reset in coordination.

Structure
REQ-026 A shared package/include SHALL hold ADDR_WIDTH, PTR_WIDTH and the bin2gray/gray2bin functions, which are also used by the write-side block.
REQ-027 The two-flop synchronizer SHALL be a separate sub-module, sync_w2r, parameterized by width.
REQ-028 Gray-to-binary conversion SHALL be an XOR prefix over the synchronized pointer, with no lookup table.

Verification
REQ-029 Reset: hold rd_rst=1 for 2 cycles -> empty=1, almost_empty=1, rd_ptr=7'h00, rd_addr=0, rd_count=0.
REQ-030 Single word: drive wrt_ptr=7'h01 -> empty=0 and rd_count=1 after the 3rd edge. Then one rd_en pulse -> rd_addr=1, rd_ptr=7'h01, empty=1, rd_count=0.
REQ-031 Underflow guard: hold rd_en=1 with empty=1 for 10 cycles -> rd_ptr stays 7'h00 and rd_count stays 0.
REQ-032 Wrap: drive wrt_ptr=7'h60 (binary 64), then read 64 words -> rd_addr sequence is 0..63, then 0. Final rd_ptr=7'h60, empty=1 after the 64th read.
REQ-033 Threshold: drive wrt_ptr=7'h05 (binary 6) -> rd_count=6, almost_empty=0. Read 2 words -> rd_count=4, almost_empty=1.
REQ-034 Mid-operation reset: with rd_count=6 and rd_en=1, assert rd_rst for 1 cycle -> all outputs return to their REQ-024 values on the next edge.
